// File: rtl/div_result_bcd.sv
// div_result_bcd
// Converts a signed 32-bit divider result (quotient or remainder) into a
// sign flag plus a 10-digit BCD magnitude using a serial double-dabble
// engine. A conversion starts on the falling edge of the divider's busy
// flag and completes 33 clock edges later.

module div_result_bcd (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] q,
    input  logic [31:0] r,
    input  logic        busy,
    input  logic        sel,
    output logic [39:0] bcd,
    output logic        neg,
    output logic        valid,
    output logic        conv_busy,
    output logic        overrun
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Number of double-dabble steps minus one (one step per magnitude bit)
    localparam logic [5:0] LAST_STEP = 6'd31;

    logic [1:0]  r_state;
    logic        r_busy_d;
    logic        r_sign;
    logic [31:0] r_mag;
    logic [39:0] r_scratch;
    logic [5:0]  r_cnt;
    logic [39:0] r_bcd;
    logic        r_neg;
    logic        r_valid;
    logic        r_conv_busy;
    logic        r_overrun;

    logic        w_capture;
    logic [31:0] w_word;
    logic [31:0] w_mag_load;
    logic [39:0] w_scratch_adj;

    // A capture event is the divider dropping busy after having held it high
    assign w_capture = r_busy_d & ~busy;

    // Operand chosen by sel; only consumed on the capture edge in IDLE
    assign w_word = sel ? r : q;

    // Two's-complement magnitude; 0x80000000 maps to 2^31, which fits unsigned
    assign w_mag_load = w_word[31] ? (~w_word + 32'd1) : w_word;

    assign bcd       = r_bcd;
    assign neg       = r_neg;
    assign valid     = r_valid;
    assign conv_busy = r_conv_busy;
    assign overrun   = r_overrun;

    // Double-dabble correction: add 3 to every BCD digit that is 5 or more
    always_comb begin
        // NOTE: assign a full default before the conditional updates so no path leaves the signal unassigned, which would infer a latch.
        w_scratch_adj = r_scratch;
        for (int i = 0; i < 10; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5) begin
                w_scratch_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // Delay busy by one edge for capture-event detection
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values, independent of statement order.
        if (reset) begin
            r_busy_d <= 1'b0;
        end else begin
            r_busy_d <= busy;
        end
    end

    // Sticky flag for capture events that arrive while a conversion is running
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_capture && (r_state != ST_IDLE)) begin
            r_overrun <= 1'b1;
        end
    end

    // Conversion FSM and double-dabble datapath
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_sign    <= 1'b0;
            r_mag     <= 32'd0;
            r_scratch <= 40'd0;
            r_cnt     <= 6'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_capture) begin
                        r_sign    <= w_word[31];
                        r_mag     <= w_mag_load;
                        r_scratch <= 40'd0;
                        r_cnt     <= 6'd0;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Shift {scratch, magnitude} left by one after correction
                    r_scratch <= {w_scratch_adj[38:0], r_mag[31]};
                    r_mag     <= {r_mag[30:0], 1'b0};
                    r_cnt     <= r_cnt + 6'd1;
                    if (r_cnt == LAST_STEP) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output registers: result and status change only at capture and DONE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bcd       <= 40'd0;
            r_neg       <= 1'b0;
            r_valid     <= 1'b0;
            r_conv_busy <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && w_capture) begin
                r_valid     <= 1'b0;
                r_conv_busy <= 1'b1;
            end else if (r_state == ST_DONE) begin
                r_bcd       <= r_scratch;
                r_neg       <= r_sign;
                r_valid     <= 1'b1;
                r_conv_busy <= 1'b0;
            end
        end
    end

endmodule
